// File: rtl/counter_pkg.sv
// Shared types and defaults for the counter_ctrl sequencing controller.
package counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef logic [1:0] ctrl_state_t;

  localparam ctrl_state_t IDLE  = 2'd0;
  localparam ctrl_state_t RUN   = 2'd1;
  localparam ctrl_state_t PAUSE = 2'd2;

endpackage

// File: rtl/counter_ctrl_tick_gen.sv
// Prescaler: emits a step every PRESCALE enabled cycles, holding phase while disabled.
module tick_gen #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic res,
  input  logic clr,
  input  logic en,
  output logic step
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;
  logic [PW-1:0] phase_d;

  assign step = en && (phase == LAST);

  always_comb begin
    phase_d = phase;
    if (clr) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = (phase == LAST) ? '0 : PW'(phase + 1'b1);
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      phase <= '0;
    end else begin
      phase <= phase_d;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Start/pause/abort sequencer for an up-counter with one-shot and periodic modes.
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] limit,
  input  logic             periodic,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             paused,
  output logic             done
);

  ctrl_state_t      state;
  ctrl_state_t      state_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_inc;
  logic [WIDTH-1:0] lim_r;
  logic [WIDTH-1:0] lim_d;
  logic             per_r;
  logic             per_d;
  logic             done_d;
  logic             busy_d;
  logic             paused_d;
  logic             step;
  logic             tick_en;
  logic             tick_clr;

  assign q_inc    = WIDTH'(q + 1'b1);
  assign tick_en  = (state == RUN) && !pause && !abort;
  assign tick_clr = ((state == IDLE) && start) || abort;

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk (clk),
    .res (res),
    .clr (tick_clr),
    .en  (tick_en),
    .step(step)
  );

  // Next-state and output decode; priority abort > pause > start > step.
  always_comb begin
    state_d = state;
    q_d     = q;
    lim_d   = lim_r;
    per_d   = per_r;
    done_d  = 1'b0;

    if (abort) begin
      state_d = IDLE;
      q_d     = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            q_d = '0;
            if (limit != '0) begin
              lim_d   = limit;
              per_d   = periodic;
              state_d = RUN;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (step) begin
            if (q == lim_r) begin
              // Explicit wrap for periodic mode; one-shot never steps from lim_r.
              q_d = '0;
            end else begin
              q_d = q_inc;
              if (q_inc == lim_r) begin
                done_d = 1'b1;
                if (!per_r) begin
                  state_d = IDLE;
                end
              end
            end
          end
        end
        PAUSE: begin
          if (start) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
          q_d     = '0;
        end
      endcase
    end

    busy_d   = (state_d == RUN) || (state_d == PAUSE);
    paused_d = (state_d == PAUSE);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state  <= IDLE;
      q      <= '0;
      lim_r  <= '0;
      per_r  <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
      paused <= 1'b0;
    end else begin
      state  <= state_d;
      q      <= q_d;
      lim_r  <= lim_d;
      per_r  <= per_d;
      done   <= done_d;
      busy   <= busy_d;
      paused <= paused_d;
    end
  end

endmodule
